// File: rtl/seq_pkg.sv
// Shared definitions for the sprite sequencer slice: FSM states, VGA widths,
// and the seven-segment table used by the board-level HEX displays.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        HOLD,
        END_DRAW,
        END
    } state_t;

    localparam int VGA_X_W = 9;
    localparam int VGA_Y_W = 8;

    // Active-low segments {g,f,e,d,c,b,a}; blanks anything above 9.
    function automatic logic [6:0] hex_decoder(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_round_timer.sv
// Two-digit BCD seconds counter with a clock prescaler; stops and raises a
// sticky expired flag when the count reaches ROUND_SECS.
module bcd_round_timer #(
    parameter int CLK_HZ     = 50000000,
    parameter int ROUND_SECS = 30
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       run,
    output logic [3:0] secs_ones,
    output logic [3:0] secs_tens,
    output logic       expired
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [7:0] TARGET = {4'(ROUND_SECS / 10), 4'(ROUND_SECS % 10)};

    logic [PRE_W-1:0] pre;
    logic [3:0]       next_ones;
    logic [3:0]       next_tens;

    always_comb begin
        next_ones = secs_ones + 4'd1;
        next_tens = secs_tens;
        if (secs_ones == 4'd9) begin
            next_ones = 4'd0;
            next_tens = secs_tens + 4'd1;
        end
    end

    // Digits freeze once expired; the target compare uses the post-tick value.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            pre       <= '0;
            secs_ones <= 4'd0;
            secs_tens <= 4'd0;
            expired   <= 1'b0;
        end else if (run && !expired) begin
            if (pre == PRE_W'(CLK_HZ - 1)) begin
                pre       <= '0;
                secs_ones <= next_ones;
                secs_tens <= next_tens;
                if ({next_tens, next_ones} == TARGET)
                    expired <= 1'b1;
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_frame_sequencer.sv
// Cycles sprite ROM frames into a VGA window with a hold between draws; on
// round-timer expiry draws the end frame once and parks with done high.
module sprite_frame_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_FRAMES  = 3,
    parameter int W           = 320,
    parameter int H           = 165,
    parameter int X0          = 0,
    parameter int Y0          = 75,
    parameter int COL_W       = 3,
    parameter int HOLD_CYCLES = 100000000,
    parameter int CLK_HZ      = 50000000,
    parameter int ROUND_SECS  = 30,
    localparam int ADDR_W     = $clog2(W * H),
    localparam int FS_W       = $clog2(NUM_FRAMES + 1)
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic [FS_W-1:0]    frame_sel,
    input  logic [COL_W-1:0]   rom_colour,
    output logic [8:0]         x,
    output logic [7:0]         y,
    output logic [COL_W-1:0]   colour,
    output logic               plot,
    output logic [3:0]         secs_ones,
    output logic [3:0]         secs_tens,
    output logic               done
);

    localparam int CX_W   = (W > 1) ? $clog2(W) : 1;
    localparam int RY_W   = (H > 1) ? $clog2(H) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    if (X0 + W > 320) begin : g_x_range
        $error("sprite window exceeds 320 columns");
    end
    if (Y0 + H > 240) begin : g_y_range
        $error("sprite window exceeds 240 rows");
    end

    state_t            state;
    logic [CX_W-1:0]   col;
    logic [RY_W-1:0]   row;
    logic [HOLD_W-1:0] hold_cnt;
    logic              expired;
    logic              run;
    logic              last_px;

    assign run     = (state != IDLE);
    assign last_px = (col == CX_W'(W - 1)) && (row == RY_W'(H - 1));

    bcd_round_timer #(
        .CLK_HZ     (CLK_HZ),
        .ROUND_SECS (ROUND_SECS)
    ) u_timer (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .run       (run),
        .secs_ones (secs_ones),
        .secs_tens (secs_tens),
        .expired   (expired)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            hold_cnt  <= '0;
            rom_addr  <= '0;
            frame_sel <= '0;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            done      <= 1'b0;
        end else begin
            plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= DRAW;
                        col       <= '0;
                        row       <= '0;
                        rom_addr  <= '0;
                        frame_sel <= '0;
                    end
                end
                // rom_colour belongs to the address on rom_addr this cycle, so
                // the pixel lands alongside its coordinates one clock later.
                DRAW, END_DRAW: begin
                    plot   <= 1'b1;
                    x      <= VGA_X_W'(X0 + 32'(col));
                    y      <= VGA_Y_W'(Y0 + 32'(row));
                    colour <= rom_colour;
                    if (last_px) begin
                        col      <= '0;
                        row      <= '0;
                        rom_addr <= '0;
                        hold_cnt <= '0;
                        if (state == END_DRAW) begin
                            state <= END;
                            done  <= 1'b1;
                        end else if (expired) begin
                            state     <= END_DRAW;
                            frame_sel <= FS_W'(NUM_FRAMES);
                        end else begin
                            state <= HOLD;
                        end
                    end else begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                        if (col == CX_W'(W - 1)) begin
                            col <= '0;
                            row <= row + RY_W'(1);
                        end else begin
                            col <= col + CX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (expired) begin
                        state     <= END_DRAW;
                        frame_sel <= FS_W'(NUM_FRAMES);
                    end else if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state     <= DRAW;
                        frame_sel <= (frame_sel == FS_W'(NUM_FRAMES - 1)) ? '0 : frame_sel + FS_W'(1);
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                END: done <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
